// File: rtl/accum_pkg.sv
// Shared definitions for the serial accumulator: FSM state encodings and the
// width of the carry-count extension.
package accum_pkg;

  localparam logic [0:0] StAccum = 1'b0;
  localparam logic [0:0] StDone  = 1'b1;

  // Carry-count width: wide enough that COUNT*(2^SIZE-1) never wraps acc_hi.
  function automatic int unsigned hw_width(input int unsigned count);
    return $clog2(count + 1);
  endfunction

endpackage

// File: rtl/serial_accumulator_if.sv
// Operand-in / result-out handshake bundle for the serial accumulator.
interface serial_accumulator_if
  import accum_pkg::*;
#(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned COUNT = 4
);

  localparam int unsigned HW = hw_width(COUNT);

  logic                in_valid;
  logic                in_ready;
  logic [SIZE-1:0]     in_data;
  logic                out_valid;
  logic                out_ready;
  logic [SIZE+HW-1:0]  out_sum;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum
  );

endinterface

// File: rtl/ripplecarrryadder.sv
// Parameterised ripple-carry adder: sum = a + b + cin, carry-out on cout.
module ripplecarrryadder #(
  parameter int unsigned SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  output logic [SIZE-1:0] sum,
  output logic            cout
);

  logic [SIZE:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[SIZE];

endmodule

// File: rtl/serial_accumulator.sv
// Sums COUNT unsigned operands per frame; adder carries are tallied into acc_hi
// so the {acc_hi, acc_lo} result is exact.
module serial_accumulator
  import accum_pkg::*;
#(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned COUNT = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  clear,
  serial_accumulator_if.slave  bus
);

  localparam int unsigned HW = hw_width(COUNT);
  localparam int unsigned IW = $clog2(COUNT);

  logic [0:0]      state_q, state_d;
  logic [SIZE-1:0] acc_lo_q, acc_lo_d;
  logic [HW-1:0]   acc_hi_q, acc_hi_d;
  logic [IW-1:0]   idx_q, idx_d;

  logic [SIZE-1:0] add_sum;
  logic            add_cout;

  ripplecarrryadder #(
    .SIZE (SIZE)
  ) u_adder (
    .a    (acc_lo_q),
    .b    (bus.in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d  = state_q;
    acc_lo_d = acc_lo_q;
    acc_hi_d = acc_hi_q;
    idx_d    = idx_q;
    // clear wins over any simultaneous handshake, which is simply dropped
    if (clear) begin
      state_d  = StAccum;
      acc_lo_d = '0;
      acc_hi_d = '0;
      idx_d    = '0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (bus.in_valid) begin
            acc_lo_d = add_sum;
            if (add_cout) acc_hi_d = acc_hi_q + {{(HW-1){1'b0}}, 1'b1};
            idx_d = idx_q + {{(IW-1){1'b0}}, 1'b1};
            if (idx_q == IW'(COUNT - 1)) state_d = StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_d  = StAccum;
            acc_lo_d = '0;
            acc_hi_d = '0;
            idx_d    = '0;
          end
        end
        default: state_d = StAccum;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StAccum;
      acc_lo_q <= '0;
      acc_hi_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_lo_q <= acc_lo_d;
      acc_hi_q <= acc_hi_d;
      idx_q    <= idx_d;
    end
  end

  // Handshake flags decode from state alone; the sum comes straight from registers.
  assign bus.in_ready  = (state_q == StAccum);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_sum   = {acc_hi_q, acc_lo_q};

endmodule

// File: tb/tb_serial_accumulator.sv
// Directed and randomized frames for serial_accumulator, checked against an
// integer-sum reference model.
module tb_serial_accumulator;
  import accum_pkg::*;

  localparam int unsigned SIZE  = 4;
  localparam int unsigned COUNT = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;

  int unsigned errors = 0;
  int unsigned checks = 0;

  serial_accumulator_if #(.SIZE(SIZE), .COUNT(COUNT)) bus ();

  serial_accumulator #(
    .SIZE  (SIZE),
    .COUNT (COUNT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One operand transfer after 'gap' idle cycles; returns at the negedge after the edge.
  task automatic send(input logic [SIZE-1:0] v, input int unsigned gap);
    repeat (gap) begin
      bus.in_valid = 1'b0;
      bus.in_data  = SIZE'($urandom);
      @(negedge clk);
    end
    check("in_ready_accum", {31'd0, bus.in_ready}, 32'd1);
    check("out_valid_accum", {31'd0, bus.out_valid}, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = SIZE'($urandom);
  endtask

  // Full frame: send operands, check result, stall, then hand the result off.
  task automatic frame(input logic [SIZE-1:0] ops [COUNT], input int unsigned max_gap,
                       input int unsigned stall, input string tag);
    int unsigned exp = 0;
    for (int i = 0; i < int'(COUNT); i++) begin
      exp += int'(ops[i]);
      send(ops[i], $urandom_range(max_gap, 0));
    end
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
    check({tag, "_sum"}, 32'(bus.out_sum), exp);
    repeat (stall) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = SIZE'($urandom);
      @(negedge clk);
      check({tag, "_stall_sum"}, 32'(bus.out_sum), exp);
      check({tag, "_stall_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check({tag, "_stall_ready"}, {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_post_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_post_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_post_sum"}, 32'(bus.out_sum), 32'd0);
  endtask

  initial begin
    logic [SIZE-1:0] ops [COUNT];

    rst_n         = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_sum", 32'(bus.out_sum), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    ops = '{4'd3, 4'd5, 4'd7, 4'd9};
    frame(ops, 0, 0, "f3579");

    ops = '{4'd15, 4'd15, 4'd15, 4'd15};
    frame(ops, 0, 1, "f15");

    ops = '{4'd1, 4'd2, 4'd3, 4'd4};
    frame(ops, 3, 5, "f1234");

    // Abort after two operands with an input offered alongside clear.
    send(4'd8, 0);
    send(4'd8, 0);
    check("partial_sum", 32'(bus.out_sum), 32'd16);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd8;
    @(negedge clk);
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    check("clear_sum", 32'(bus.out_sum), 32'd0);
    check("clear_ready", {31'd0, bus.in_ready}, 32'd1);
    ops = '{4'd1, 4'd1, 4'd1, 4'd1};
    frame(ops, 1, 0, "f1111");

    // clear in DONE beats a simultaneous result handshake.
    for (int i = 0; i < int'(COUNT); i++) send(4'd6, 0);
    check("done_sum", 32'(bus.out_sum), 32'd24);
    clear         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    clear         = 1'b0;
    bus.out_ready = 1'b0;
    check("clr_done_valid", {31'd0, bus.out_valid}, 32'd0);
    check("clr_done_sum", 32'(bus.out_sum), 32'd0);

    // Asynchronous reset while a result is pending.
    send(4'd3, 0);
    send(4'd5, 0);
    send(4'd7, 0);
    send(4'd9, 0);
    check("pre_rst_sum", 32'(bus.out_sum), 32'd24);
    check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("async_rst_sum", 32'(bus.out_sum), 32'd0);
    check("async_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ops = '{4'd2, 4'd2, 4'd2, 4'd2};
    frame(ops, 0, 0, "f2222");

    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < int'(COUNT); i++) ops[i] = SIZE'($urandom);
      frame(ops, 3, $urandom_range(3, 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_accumulator.md
SERIAL_ACCUMULATOR -- requirements
Module: serial_accumulator

Interface
REQ-001 SHALL have parameter SIZE, default 4, giving the operand width in bits.
REQ-002 SHALL have parameter COUNT, default 4, giving the operands per frame (legal range 2..255).
REQ-003 SHALL derive local constant HW = $clog2(COUNT+1), the width of the carry-count extension.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous reset, active-low.
REQ-006 clear  input  1  synchronous frame abort.
REQ-007 in_valid  input  1  operand offered.
REQ-008 in_ready  output  1  block accepts operand.
REQ-009 in_data  input  SIZE  operand value, unsigned.
REQ-010 out_valid  output  1  frame result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_sum  output  SIZE+HW  unsigned frame total; upper HW bits are the carry count, lower SIZE bits are the accumulator.

Function
REQ-013 SHALL implement a two-state FSM: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-014 An input transfer SHALL occur on any cycle where in_valid && in_ready.
REQ-015 On each input transfer, acc_lo SHALL load the adder sum of acc_lo + in_data with carry-in 0.
REQ-016 On each input transfer, acc_hi SHALL increment by 1 when the adder MSB carry-out is 1 and hold otherwise.
REQ-017 On each input transfer, the operand index SHALL increment.
REQ-018 On the transfer with index == COUNT-1, the FSM SHALL move ACCUM->DONE.
REQ-019 out_valid and the final out_sum SHALL be visible in the cycle after the last transfer (latency 1).
REQ-020 out_sum SHALL be registered and equal {acc_hi, acc_lo}.
REQ-021 out_sum SHALL be stable while out_valid=1 && out_ready=0.
REQ-022 In DONE, on out_valid && out_ready, the FSM SHALL return to ACCUM, clearing acc_lo, acc_hi and index to 0.
REQ-023 in_ready SHALL be 1 in the cycle after the result handshake.
REQ-024 in_data SHALL be ignored when in_valid=0; no state change SHALL occur without a transfer.
REQ-025 acc_hi SHALL never wrap: HW is sized so that COUNT*(2^SIZE-1) fits in SIZE+HW bits.
REQ-026 clear=1 SHALL, in either state, force ACCUM and zero acc_lo, acc_hi and index on the next edge.
REQ-027 clear=1 SHALL take priority over a simultaneous input or output handshake; that handshake SHALL be discarded.
REQ-028 in_ready SHALL depend on FSM state only, never combinationally on in_valid or out_ready.

Reset
REQ-029 While rst_n=0, the FSM SHALL be in ACCUM, asynchronously.
REQ-030 While rst_n=0, acc_lo, acc_hi and index SHALL be 0, asynchronously.
REQ-031 While rst_n=0, the outputs SHALL be in_ready=1, out_valid=0 and out_sum=0.
REQ-032 Reset asserted mid-frame or in DONE SHALL discard the partial or pending result.
REQ-033 The first transfer after rst_n deasserts SHALL count as operand index 0.

Structure
REQ-034 The addition SHALL use one instance of the team's existing parameterised ripple-carry adder (ripplecarrryadder, SIZE passed through); no behavioural '+' SHALL be used on acc_lo.
REQ-035 The carry-count increment on acc_hi SHALL be a plain counter.
REQ-036 FSM state encodings SHALL live in a shared package, accum_pkg.
REQ-037 The HW derivation SHALL live in accum_pkg.
REQ-038 No other sub-module SHALL be used.

Verification (SIZE=4, COUNT=4, HW=3)
REQ-039 SHALL cover: operands 3,5,7,9 back-to-back -> out_valid one cycle after fourth transfer, out_sum=24 (0x18).
REQ-040 SHALL cover: operands 15,15,15,15 -> out_sum=60 (acc_hi=3, acc_lo=12).
REQ-041 SHALL cover: operands 1,2,3,4 with in_valid gaps, then out_ready held 0 for 5 cycles -> out_sum=10 stable throughout, in_ready=0 until handshake.
REQ-042 SHALL cover: clear asserted with in_valid=1 after two operands 8,8, then frame 1,1,1,1 -> out_sum=4.
REQ-043 SHALL cover: rst_n pulsed low in DONE holding out_sum=24 -> out_valid=0 and out_sum=0 immediately; next frame 2,2,2,2 -> out_sum=8.
